// File: rtl/vseq_pkg.sv
// Shared types and defaults for the vector memory sequencer.
// The lane-index width helper keeps a one-lane build at one bit.
package vseq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DRAIN,
    DONE
  } state_t;

  localparam int DW_DEF    = 32;
  localparam int AW_DEF    = 8;
  localparam int LANES_DEF = 4;

  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vseq_addr_gen.sv
// Lane address generator: base + lane*STRIDE.
// Returns the wrapped address and a flag when the true sum exceeds AW bits.
module vseq_addr_gen #(
  parameter int AW     = 8,
  parameter int LW     = 2,
  parameter int STRIDE = 1
) (
  input  logic [AW-1:0] base,
  input  logic [LW-1:0] lane,
  output logic [AW-1:0] addr,
  output logic          ovf
);

  localparam int EW = AW + 33;

  logic [EW-1:0] full;

  assign full = EW'(base) + EW'(lane) * EW'(STRIDE);
  assign addr = full[AW-1:0];
  assign ovf  = |full[EW-1:AW];

endmodule

// File: rtl/vector_mem_sequencer.sv
// Scalar/vector load-store sequencer onto a single-port one-word memory.
// Define VSEQ_BOUNDS_CHECK_EN to suppress out-of-range lanes and add err.
module vector_mem_sequencer
  import vseq_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int AW     = AW_DEF,
  parameter int LANES  = LANES_DEF,
  parameter int STRIDE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic                vector_op,
  input  logic [AW-1:0]       base_addr,
  input  logic [DW-1:0]       wdata_s,
  input  logic [LANES*DW-1:0] wdata_v,
  input  logic [DW-1:0]       mem_rdata,
  output logic [AW-1:0]       mem_addr,
  output logic                mem_re,
  output logic                mem_we,
  output logic [DW-1:0]       mem_wdata,
  output logic                stall,
  output logic                done,
  output logic [DW-1:0]       rdata_s,
  output logic [LANES*DW-1:0] rdata_v
`ifdef VSEQ_BOUNDS_CHECK_EN
  ,
  output logic                err
`endif
);

  localparam int LW = lane_w(LANES);

  state_t state, state_nx;

  logic [LW-1:0]       lane;
  logic [LW-1:0]       last;
  logic                is_load;
  logic                is_vec;
  logic [AW-1:0]       base;
  logic [LANES*DW-1:0] wbuf;

  logic                pend;
  logic                pend_zero;
  logic                pend_vec;
  logic [LW-1:0]       pend_lane;

  logic [AW-1:0]       lane_addr;
  logic                lane_ovf;
  logic                sup;
  logic                accept;

  vseq_addr_gen #(
    .AW     (AW),
    .LW     (LW),
    .STRIDE (STRIDE)
  ) u_addr (
    .base (base),
    .lane (lane),
    .addr (lane_addr),
    .ovf  (lane_ovf)
  );

`ifdef VSEQ_BOUNDS_CHECK_EN
  assign sup = lane_ovf;
`else
  logic unused;
  assign sup    = 1'b0;
  assign unused = lane_ovf;
`endif

  // Held in reset, nothing may be accepted or stalled.
  assign accept = ~rst & (state == IDLE) & req_valid
                & (mem_read ^ mem_write);

  always_comb begin
    state_nx  = state;
    mem_addr  = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    stall     = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          stall    = 1'b1;
          state_nx = XFER;
        end
      end
      XFER: begin
        stall = 1'b1;
        if (!sup) begin
          mem_addr = lane_addr;
          mem_re   = is_load;
          mem_we   = ~is_load;
          if (!is_load)
            mem_wdata = wbuf[int'(lane)*DW +: DW];
        end
        if (lane == last)
          state_nx = is_load ? DRAIN : DONE;
      end
      DRAIN: begin
        stall    = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lane      <= '0;
      last      <= '0;
      is_load   <= 1'b0;
      is_vec    <= 1'b0;
      base      <= '0;
      wbuf      <= '0;
      pend      <= 1'b0;
      pend_zero <= 1'b0;
      pend_vec  <= 1'b0;
      pend_lane <= '0;
      rdata_s   <= '0;
      rdata_v   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        lane    <= '0;
        is_load <= mem_read;
        is_vec  <= vector_op;
        base    <= base_addr;
        last    <= vector_op ? LW'(LANES-1) : '0;
        wbuf    <= vector_op ? wdata_v
                             : (LANES*DW)'(wdata_s);
      end else if (state == XFER) begin
        lane <= (lane == last) ? '0 : lane + 1'b1;
      end
      // Read data returns one cycle after the strobe.
      pend      <= (state == XFER) & is_load;
      pend_lane <= lane;
      pend_zero <= sup;
      pend_vec  <= is_vec;
      if (pend) begin
        if (pend_vec)
          rdata_v[int'(pend_lane)*DW +: DW] <=
            pend_zero ? '0 : mem_rdata;
        else
          rdata_s <= pend_zero ? '0 : mem_rdata;
      end
    end
  end

`ifdef VSEQ_BOUNDS_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err <= 1'b0;
    else if ((state == XFER) && sup)
      err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed bench for vector_mem_sequencer with a behavioural memory
// and queues of expected memory accesses.
module tb_vector_mem_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic         vector_op = 1'b0;
  logic [7:0]   base_addr = '0;
  logic [31:0]  wdata_s = '0;
  logic [127:0] wdata_v = '0;
  logic [31:0]  mem_rdata = '0;
  logic [7:0]   mem_addr;
  logic         mem_re;
  logic         mem_we;
  logic [31:0]  mem_wdata;
  logic         stall;
  logic         done;
  logic [31:0]  rdata_s;
  logic [127:0] rdata_v;
`ifdef VSEQ_BOUNDS_CHECK_EN
  logic         err;
`endif

  vector_mem_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .vector_op (vector_op),
    .base_addr (base_addr),
    .wdata_s   (wdata_s),
    .wdata_v   (wdata_v),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .stall     (stall),
    .done      (done),
    .rdata_s   (rdata_s),
    .rdata_v   (rdata_v)
`ifdef VSEQ_BOUNDS_CHECK_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
    int          cyc;
  } acc_t;

  acc_t wq[$];
  acc_t rq[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_w(input logic [7:0] a,
                        input logic [31:0] d, input int cyc);
    acc_t e;
    e.a = a; e.d = d; e.cyc = cyc;
    wq.push_back(e);
  endtask

  task automatic push_r(input logic [7:0] a, input int cyc);
    acc_t e;
    e.a = a; e.d = '0; e.cyc = cyc;
    rq.push_back(e);
  endtask

  // Drives one request; cycle 0 is the accept cycle.
  task automatic run_req(input string nm,
                         input logic rd, input logic wr,
                         input logic vec, input logic [7:0] ba,
                         input logic [127:0] wv,
                         input logic [31:0] ws,
                         input int exp_done, input bit hold);
    bit seen;
    acc_t e;
    seen = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; mem_read = rd; mem_write = wr;
    vector_op = vec; base_addr = ba;
    wdata_v = wv; wdata_s = ws;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      chk({nm, "_stall"}, 128'(stall),
          128'((exp_done >= 0) && (c < exp_done)));
      if (mem_we) begin
        if (wq.size() == 0) begin
          chk({nm, "_unexp_we"}, 128'(mem_addr), 128'hX);
        end else begin
          e = wq.pop_front();
          chk({nm, "_waddr"}, 128'(mem_addr), 128'(e.a));
          chk({nm, "_wdata"}, 128'(mem_wdata), 128'(e.d));
          chk({nm, "_wcyc"}, 128'(c), 128'(e.cyc));
        end
      end
      if (mem_re) begin
        if (rq.size() == 0) begin
          chk({nm, "_unexp_re"}, 128'(mem_addr), 128'hX);
        end else begin
          e = rq.pop_front();
          chk({nm, "_raddr"}, 128'(mem_addr), 128'(e.a));
          chk({nm, "_rcyc"}, 128'(c), 128'(e.cyc));
        end
      end
      if (done) begin
        chk({nm, "_done_cyc"}, 128'(c), 128'(exp_done));
        seen = 1;
      end else begin
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    if (!seen && exp_done >= 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL %s_timeout: observed no done expected cycle %0d",
             nm, exp_done);
    end
    chk({nm, "_wq_left"}, 128'(wq.size()), 128'd0);
    chk({nm, "_rq_left"}, 128'(rq.size()), 128'd0);
    wq.delete();
    rq.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] exp_v;
    logic [127:0] v0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hC000_0000 | i;
    mem[8'h40] = 32'hA0A0_000A;
    mem[8'h41] = 32'hB0B0_000B;
    mem[8'h42] = 32'hC0C0_000C;
    mem[8'h43] = 32'hD0D0_000D;
    mem[8'h10] = 32'h0000_DEAD;

    // Reset state, with a request pending while held in reset
    req_valid = 1'b1; mem_read = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 128'(stall), 128'd0);
    chk("rst_strobes", 128'({mem_re, mem_we, done}), 128'd0);
    chk("rst_addr", 128'({mem_addr, mem_wdata}), 128'd0);
    chk("rst_rdata_s", 128'(rdata_s), 128'd0);
    chk("rst_rdata_v", rdata_v, 128'd0);
`ifdef VSEQ_BOUNDS_CHECK_EN
    chk("rst_err", 128'(err), 128'd0);
`endif
    req_valid = 1'b0; mem_read = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // 1: vector store, request held high during the transfer
    v0 = {32'd4, 32'd3, 32'd2, 32'd1};
    for (int i = 0; i < 4; i++)
      push_w(8'h20 + 8'(i), 32'(i + 1), i + 1);
    run_req("vst", 1'b0, 1'b1, 1'b1, 8'h20, v0, 32'h0, 5, 1'b1);
    chk("vst_rdata_v", rdata_v, 128'd0);

    // 2: vector load
    for (int i = 0; i < 4; i++) push_r(8'h40 + 8'(i), i + 1);
    run_req("vld", 1'b1, 1'b0, 1'b1, 8'h40, '0, '0, 6, 1'b0);
    exp_v = {32'hD0D0_000D, 32'hC0C0_000C,
             32'hB0B0_000B, 32'hA0A0_000A};
    chk("vld_rdata_v", rdata_v, exp_v);
    chk("vld_rdata_s", 128'(rdata_s), 128'd0);

    // 3: scalar load
    push_r(8'h10, 1);
    run_req("sld", 1'b1, 1'b0, 1'b0, 8'h10, '0, '0, 3, 1'b0);
    chk("sld_rdata_s", 128'(rdata_s), 128'h0000_DEAD);
    chk("sld_rdata_v", rdata_v, exp_v);

    // Scalar store leaves both load results untouched
    push_w(8'h30, 32'h0000_0055, 1);
    run_req("sst", 1'b0, 1'b1, 1'b0, 8'h30, '0, 32'h55, 2, 1'b0);
    chk("sst_rdata_s", 128'(rdata_s), 128'h0000_DEAD);
    chk("sst_rdata_v", rdata_v, exp_v);

    // 4: vector load crossing the top of the address space
`ifdef VSEQ_BOUNDS_CHECK_EN
    push_r(8'hFE, 1);
    push_r(8'hFF, 2);
    run_req("wrap", 1'b1, 1'b0, 1'b1, 8'hFE, '0, '0, 6, 1'b0);
    exp_v = {32'd0, 32'd0, 32'hC000_00FF, 32'hC000_00FE};
    chk("wrap_rdata_v", rdata_v, exp_v);
    chk("wrap_err", 128'(err), 128'd1);
`else
    push_r(8'hFE, 1);
    push_r(8'hFF, 2);
    push_r(8'h00, 3);
    push_r(8'h01, 4);
    run_req("wrap", 1'b1, 1'b0, 1'b1, 8'hFE, '0, '0, 6, 1'b0);
    exp_v = {32'hC000_0001, 32'hC000_0000,
             32'hC000_00FF, 32'hC000_00FE};
    chk("wrap_rdata_v", rdata_v, exp_v);
`endif

    // 5: read and write together is ignored
    run_req("ill", 1'b1, 1'b1, 1'b1, 8'h70, '0, '0, -1, 1'b1);
    mem_write = 1'b0;

    // 6: reset in the second XFER cycle of a vector store
    @(posedge clk); #1;
    req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1;
    vector_op = 1'b1; base_addr = 8'h50;
    wdata_v = {32'h44, 32'h33, 32'h22, 32'h11};
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_we", 128'({mem_we, mem_addr, mem_wdata}),
        128'({1'b1, 8'h51, 32'h22}));
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_we", 128'(mem_we), 128'd0);
    chk("mid_rst_stall", 128'(stall), 128'd0);
    chk("mid_rst_rdata_v", rdata_v, 128'd0);
    @(posedge clk); @(negedge clk);
    chk("mid_rst_hold", 128'({mem_we, mem_re, stall, done}), 128'd0);
    @(posedge clk); #1 rst = 1'b0;

    push_w(8'h60, 32'h0000_0077, 1);
    run_req("post", 1'b0, 1'b1, 1'b0, 8'h60, '0, 32'h77, 2, 1'b0);

    // Back-to-back: accept in the IDLE cycle right after DONE
    push_r(8'h60, 1);
    run_req("b2b", 1'b1, 1'b0, 1'b0, 8'h60, '0, '0, 3, 1'b0);
    chk("b2b_rdata_s", 128'(rdata_s), 128'h0000_0077);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
